// File: rtl/hash_arbiter.sv
// Round-robin arbiter/sequencer sharing one SHA-256 core; req->gnt/hash_start 1 cycle, hash_done rise->done 1 cycle.
// No backpressure: req is level-held until done, sampled only in IDLE. Optional watchdog: HASH_TIMEOUT_EN.
module hash_arbiter #(
  parameter int N_REQ   = 4,
  parameter int IDW     = $clog2(N_REQ),
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   owner_id,
  output logic             busy,
  output logic             hash_start,
  input  logic             hash_done,
  output logic [N_REQ-1:0] done,
  output logic             err
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_CLEAR, S_RUN, S_RESP} state_t;

  state_t           state_q;
  logic [IDW-1:0]   owner_q, ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, done_q;
  logic             busy_q, start_q, err_q;
  logic             win_vld;
  logic [IDW-1:0]   win_idx;
  logic             timeout_hit;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Search upward from ptr, wrapping at N_REQ so unused index codes never win.
  always_comb begin
    int cand;
    cand    = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_vld && req[IDW'(cand)]) begin
        win_vld = 1'b1;
        win_idx = IDW'(cand);
      end
    end
  end

  assign ptr_d = (owner_q == IDW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef HASH_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wdog_q, wdog_d;

  assign wdog_d      = wdog_q + 1'b1;
  assign timeout_hit = ((state_q == S_CLEAR) || (state_q == S_RUN)) && (wdog_d == WDW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       wdog_q <= '0;
    else if (state_q == S_LAUNCH)                     wdog_q <= '0;
    else if ((state_q == S_CLEAR) || (state_q == S_RUN)) wdog_q <= wdog_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            state_q <= S_LAUNCH;
            owner_q <= win_idx;
            gnt_q   <= onehot(win_idx);
            busy_q  <= 1'b1;
            start_q <= 1'b1;
          end
        end
        S_LAUNCH: begin
          start_q <= 1'b0;
          state_q <= S_CLEAR;
        end
        // The previous job's done level must drop before a rising level can count.
        S_CLEAR: begin
          if (timeout_hit) begin
            state_q <= S_RESP;
            done_q  <= onehot(owner_q);
            err_q   <= 1'b1;
          end else if (!hash_done) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (timeout_hit) begin
            state_q <= S_RESP;
            done_q  <= onehot(owner_q);
            err_q   <= 1'b1;
          end else if (hash_done) begin
            state_q <= S_RESP;
            done_q  <= onehot(owner_q);
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ptr_q   <= ptr_d;
          gnt_q   <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign hash_start = start_q;
  assign err        = err_q;
  assign owner_id   = owner_q;

endmodule

// File: tb/tb_hash_arbiter.sv
// Bench for hash_arbiter: directed scenarios plus randomized jobs against a round-robin job-level model.
module tb_hash_arbiter;

  localparam int N  = 4;
  localparam int TO = 50;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [1:0]   owner_id;
  logic         busy;
  logic         hash_start;
  logic         hash_done;
  logic [N-1:0] done;
  logic         err;

  int ntests = 0;
  int nfail  = 0;
  int ptr_m  = 0;
  int clr_lat = 0;
  int run_lat = 2;
  int core_k  = -1;

  always #5 clk = ~clk;

  hash_arbiter #(.N_REQ(N), .IDW(2), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .gnt        (gnt),
    .owner_id   (owner_id),
    .busy       (busy),
    .hash_start (hash_start),
    .hash_done  (hash_done),
    .done       (done),
    .err        (err)
  );

  // Core model: done level drops clr_lat cycles after start, rises run_lat cycles after start, then holds.
  initial begin
    hash_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        core_k    = -1;
        hash_done = 1'b0;
      end else begin
        if (hash_start) core_k = 0;
        else if (core_k >= 0) core_k++;
        if (core_k >= 0 && core_k == clr_lat) hash_done = 1'b0;
        if (core_k >= 0 && core_k == run_lat) begin
          hash_done = 1'b1;
          core_k    = -1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return 0;
  endfunction

  // One job from an IDLE cycle: grant, hold, completion timing, pulse width, pointer rotation.
  task automatic do_job(input logic [N-1:0] r, input int cl, input int rl, input bit drop,
                        input int exp_off, input logic exp_err);
    int           w;
    int           n;
    bit           bad;
    logic [N-1:0] oh;
    w       = pick(r, ptr_m);
    oh      = '0;
    oh[w]   = 1'b1;
    clr_lat = cl;
    run_lat = rl;
    req     = r;
    n = 0;
    do begin
      @(posedge clk); #3; n++;
    end while (!hash_start && n < 8);
    chk("launch_latency", n, 1);
    chk("launch_gnt", gnt, oh);
    chk("launch_owner", owner_id, w);
    chk("launch_busy", busy, 1);
    n   = 0;
    bad = 0;
    while (done == '0 && n < 300) begin
      @(posedge clk); #3; n++;
      if (drop && n == 3) req = r & ~oh;
      if (hash_start || gnt !== oh) bad = 1;
    end
    chk("done_cycle", n, exp_off);
    chk("done_vec", done, oh);
    chk("err_flag", err, exp_err);
    chk("gnt_held_single_start", bad, 0);
    @(posedge clk); #3;
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("gnt_after_done", gnt, 0);
    ptr_m = (w + 1) % N;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", hash_start, 0);
    chk("rst_err", err, 0);
    chk("rst_owner", owner_id, 0);
    rst_n = 1'b1;
    @(posedge clk); #3;

    // Single requester with a long core run.
    do_job(4'b0010, 1, 130, 1'b0, 131, 1'b0);

    // Stale done level from the previous job is held into the new job's CLEAR phase.
    chk("stale_level_present", hash_done, 1);
    do_job(4'b1001, 3, 8, 1'b0, 9, 1'b0);

    // Requester drops req mid-job; job still completes, then stays idle.
    do_job(4'b0100, 0, 20, 1'b1, 21, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    chk("idle_stays_idle", busy, 0);

    // Asynchronous reset during RUN.
    clr_lat = 0;
    run_lat = 500;
    req     = 4'b1000;
    repeat (6) @(posedge clk);
    #3;
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_start", hash_start, 0);
    chk("arst_owner", owner_id, 0);
    req = '0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    ptr_m = 0;
    repeat (3) @(posedge clk);
    #3;
    chk("no_done_after_abort", done, 0);

    // Full contention with minimum core time: order 0,1,2,3,0 and 5-cycle start spacing.
    for (int j = 0; j < 5; j++) begin
      chk("contention_winner_model", pick(4'b1111, ptr_m), j % N);
      do_job(4'b1111, j % 2, 2, 1'b0, 3, 1'b0);
    end

    // Randomized jobs.
    for (int j = 0; j < 16; j++) begin
      logic [N-1:0] r;
      int           cl;
      int           rl;
      r  = N'($urandom_range(1, 15));
      cl = int'($urandom_range(0, 3));
      rl = cl + int'($urandom_range(2, 15));
      do_job(r, cl, rl, 1'b0, rl + 1, 1'b0);
    end

`ifdef HASH_TIMEOUT_EN
    do_job(4'b0110, 0, 100000, 1'b0, TO + 1, 1'b1);
    do_job(4'b0110, 1, 5, 1'b0, 6, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
